irq_ctrl_bamse: RTL and testbench
=================================

// Module: irq_ctrl_bamse
// PURPOSE
//  Interrupt controller between the io_bamse GPIO block (and sibling peripherals) and Pacoblaze.
//  - Edge-captures up to 8 interrupt sources into a pending register and applies a mask.
//  - Raises one interrupt line to the core, handles interrupt_ack and reports a vector.
//  - Holds off new interrupts until software writes end-of-interrupt (EOI).
//  - Mapped on the Pacoblaze port bus: port_id/port_in/port_out/wen/ren.
// PARAMETERS
//  N_SRC           4      number of sources, 1..8
//  MASK_ADDR       8'h20  port_id of mask register (R/W, 1 = enabled)
//  PEND_ADDR       8'h21  port_id of pending register (R, write-1-to-clear)
//  VEC_ADDR        8'h22  port_id of vector/status (R); any write = EOI
//  TIMEOUT_CYCLES  255    ack timeout in clk cycles (used only with IRQ_TIMEOUT_EN)
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  rst            in   1      synchronous reset, ACTIVE-LOW (reset when rst==0 at clk edge)
//  src_irq        in   N_SRC  source requests, e.g. io_bamse interrupt; rising edge = event
//  port_id        in   8      Pacoblaze port address
//  port_in        in   8      write data from Pacoblaze OUTPUT
//  port_out       out  8      read data to Pacoblaze INPUT
//  wen            in   1      write strobe, one clk
//  ren            in   1      read strobe, one clk
//  interrupt      out  1      interrupt request to Pacoblaze
//  interrupt_ack  in   1      interrupt acknowledge from Pacoblaze
// BEHAVIOUR
//  Clock and reset: single clock; reset is synchronous, active-low, on port rst.
//  Reset (rst==0): mask=0, pending=0, src_q=0, vector=0, state=IDLE, interrupt=0.
//   - port_out follows the read mux: it shows 0 at the MASK/PEND/VEC addresses and 0 elsewhere.
//   - Reset mid-operation (any state) aborts immediately. No pending is retained.
//  Edge capture:
//   - src_q <= src_irq each clk.
//   - pending[i] sets when src_irq[i] & ~src_q[i].
//   - A source held high sets pending once only.
//  Pending clear: wen at PEND_ADDR clears the bits where port_in=1.
//   - If a set and a clear hit the same bit in the same cycle, set wins.
//  Mask: wen at MASK_ADDR loads mask <= port_in[N_SRC-1:0].
//   - A masked source still latches pending but does not request.
//   - Unused upper bits read 0.
//  Request: req = |(pending & mask).
//  Priority: lowest index wins.
//  FSM:
//   - IDLE: if req, go to ASSERT next clk. interrupt=0.
//   - ASSERT: interrupt=1. On interrupt_ack:
//      - vector <= index of highest-priority active source; clear that pending bit.
//      - interrupt drops in the same edge; go to SERVICE.
//      - If the masked pending bits vanished before the ack (cleared or masked by software), return to IDLE and leave vector unchanged.
//   - SERVICE: interrupt=0. New edges still latch pending.
//      - wen at VEC_ADDR (EOI) -> IDLE.
//      - If req is still true, IDLE re-asserts after 1 clk (2 clk EOI->interrupt).
//   - interrupt_ack outside ASSERT: ignored.
//   - EOI outside SERVICE: ignored.
//  Latency: src_irq edge -> pending set after 1 clk -> interrupt high after 2 clk (from IDLE).
//  Read mux: port_out is combinational from port_id, independent of ren.
//   - MASK_ADDR -> {0,mask}.
//   - PEND_ADDR -> {0,pending}.
//   - VEC_ADDR -> {in_service(bit7), timeout_flag(bit6), 3'b0, vector[2:0]}.
//   - Any other address -> 8'h00.
//   - ren has no side effects (reads never clear).
//   - Several bus peripherals are ORed on port_out, so 0 is required when unaddressed.
// CONFIGURATION
//  IRQ_TIMEOUT_EN defined:
//   - An 8..16-bit counter runs while in ASSERT.
//   - If TIMEOUT_CYCLES pass without interrupt_ack: interrupt drops, go to IDLE, timeout_flag <= 1.
//   - Pending is kept, so the request re-arbitrates.
//   - timeout_flag clears on EOI or reset.
//  IRQ_TIMEOUT_EN undefined: no counter; ASSERT waits forever; bit6 reads 0.
// TESTING
//  1. rst=0 for 2 clk -> interrupt=0; port_out=00 at 8'h20/21/22.
//  2. Mask=8'h01, pulse src_irq[0] -> pending=01 after 1 clk, interrupt=1 after 2 clk.
//     Then ack -> interrupt=0, VEC read=8'h80; EOI -> VEC=8'h00.
//  3. Mask=8'h0F, src_irq 4'b0110 same clk -> ack gives vector 1, PEND=04.
//     EOI -> interrupt re-asserts; ack gives vector 2.
//  4. Mask=0, edge src 3 -> PEND=08, interrupt stays 0.
//     Write 8'h08 to PEND -> 00. Edge + clear in same clk -> PEND=08.
//  5. Hold src_irq[0]=1 for 50 clk -> exactly one pending set.
//     rst=0 during SERVICE -> IDLE, all registers 0.
//  6. With IRQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> interrupt drops at 16 clk, VEC bit6=1.
//     Re-asserts 1 clk later.

Source files
------------

// File: rtl/irq_ctrl_bamse.sv
// Edge-capturing interrupt controller for Pacoblaze: pending/mask registers, one IRQ line, ack/EOI handshake.
// Optional feature macro IRQ_TIMEOUT_EN: an unacknowledged ASSERT gives up after TIMEOUT_CYCLES and re-arbitrates.
module irq_ctrl_bamse #(
   parameter int         N_SRC          = 4,
   parameter logic [7:0] MASK_ADDR      = 8'h20,
   parameter logic [7:0] PEND_ADDR      = 8'h21,
   parameter logic [7:0] VEC_ADDR       = 8'h22,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_irq,
   input  logic [7:0]       port_id,
   input  logic [7:0]       port_in,
   output logic [7:0]       port_out,
   input  logic             wen,
   input  logic             ren,
   output logic             interrupt,
   input  logic             interrupt_ack
);

   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_SRC-1:0] r_src_q;
   logic [N_SRC-1:0] r_pend;
   logic [N_SRC-1:0] r_mask;
   logic [2:0]       r_vec;

   logic [N_SRC-1:0] w_set;
   logic [N_SRC-1:0] w_clr;
   logic [N_SRC-1:0] w_act;
   logic [N_SRC-1:0] w_onehot;
   logic [2:0]       w_idx;
   logic             w_req;
   logic             w_wr_mask;
   logic             w_wr_pend;
   logic             w_wr_vec;
   logic             w_ack_take;
   logic             w_eoi;
   logic             w_tmo_hit;
   logic             w_tmo_flag;
   logic [7:0]       w_mask8;
   logic [7:0]       w_pend8;
   logic             w_unused;

   assign w_wr_mask = wen && (port_id == MASK_ADDR);
   assign w_wr_pend = wen && (port_id == PEND_ADDR);
   assign w_wr_vec  = wen && (port_id == VEC_ADDR);
   assign w_eoi     = w_wr_vec && (r_state == S_SERVICE);

   assign w_set = src_irq & ~r_src_q;
   assign w_act = r_pend & r_mask;
   assign w_req = |w_act;

   // Scan from the top so the lowest active index is the last one written.
   always_comb begin
      w_idx = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_act[i]) w_idx = 3'(i);
      end
   end

   assign w_onehot = N_SRC'(1) << w_idx;

   // A new edge on a bit beats any clear of that bit in the same cycle.
   assign w_clr = (w_wr_pend  ? port_in[N_SRC-1:0] : '0)
                | (w_ack_take ? w_onehot           : '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_src_q <= '0;
         r_pend  <= '0;
         r_mask  <= '0;
         r_vec   <= 3'd0;
      end else begin
         r_src_q <= src_irq;
         r_pend  <= (r_pend & ~w_clr) | w_set;
         if (w_wr_mask) r_mask <= port_in[N_SRC-1:0];
         if (w_ack_take) r_vec <= w_idx;
      end
   end

`ifdef IRQ_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

   logic [CNT_W-1:0] r_cnt;
   logic             r_tmo_flag;

   assign w_tmo_hit  = (r_state == S_ASSERT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_tmo_flag = r_tmo_flag;
   assign w_unused   = ^{ren, port_in};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_tmo_flag <= 1'b0;
      end else begin
         r_cnt <= (r_state == S_ASSERT) ? r_cnt + 1'b1 : '0;
         if (w_tmo_hit && !interrupt_ack) r_tmo_flag <= 1'b1;
         else if (w_eoi)                  r_tmo_flag <= 1'b0;
      end
   end
`else
   assign w_tmo_hit  = 1'b0;
   assign w_tmo_flag = 1'b0;
   assign w_unused   = ^{ren, port_in, 32'(TIMEOUT_CYCLES)};
`endif

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ack_take  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_state_nxt = S_ASSERT;
         end
         S_ASSERT: begin
            if (interrupt_ack) begin
               // Software may have cleared or masked the request before the ack landed.
               if (w_req) begin
                  w_ack_take  = 1'b1;
                  w_state_nxt = S_SERVICE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SERVICE: begin
            if (w_eoi) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign interrupt = (r_state == S_ASSERT);

   // Bus is wired-OR across peripherals, so unaddressed reads must return zero.
   always_comb begin
      w_mask8 = 8'h00;
      w_pend8 = 8'h00;
      w_mask8[N_SRC-1:0] = r_mask;
      w_pend8[N_SRC-1:0] = r_pend;
      if (port_id == MASK_ADDR)      port_out = w_mask8;
      else if (port_id == PEND_ADDR) port_out = w_pend8;
      else if (port_id == VEC_ADDR)  port_out = {(r_state == S_SERVICE), w_tmo_flag, 3'b000, r_vec};
      else                           port_out = 8'h00;
   end

endmodule

// File: tb/tb_irq_ctrl_bamse.sv
// Scoreboard bench for irq_ctrl_bamse: stimulus queues expected read/IRQ values, a negedge monitor checks them.
module tb_irq_ctrl_bamse;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] src_irq = 4'h0;
   logic [7:0] port_id = 8'h00;
   logic [7:0] port_in = 8'h00;
   logic [7:0] port_out;
   logic       wen = 1'b0;
   logic       ren = 1'b0;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;
   logic       chk_irq = 1'b0;

   typedef struct {
      string      name;
      logic [7:0] exp;
      bit         is_irq;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   irq_ctrl_bamse #(
      .N_SRC(4), .MASK_ADDR(8'h20), .PEND_ADDR(8'h21), .VEC_ADDR(8'h22), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .src_irq(src_irq), .port_id(port_id), .port_in(port_in),
      .port_out(port_out), .wen(wen), .ren(ren), .interrupt(interrupt),
      .interrupt_ack(interrupt_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
      $fatal(1, "watchdog");
   end

   // Monitor: the DUT presents data whenever a read strobe or IRQ probe is active.
   always @(negedge clk) begin
      exp_t e;
      if (ren) begin
         n_vec++;
         if (q.size() == 0 || q[0].is_irq) begin
            n_miss++;
            $display("FAIL read_unexpected: port_id=%02h got %02h, no read expectation queued", port_id, port_out);
         end else begin
            e = q.pop_front();
            if (port_out !== e.exp) begin
               n_miss++;
               $display("FAIL %s: port_out got %02h expected %02h", e.name, port_out, e.exp);
            end
         end
      end
      if (chk_irq) begin
         n_vec++;
         if (q.size() == 0 || !q[0].is_irq) begin
            n_miss++;
            $display("FAIL irq_unexpected: interrupt got %b, no irq expectation queued", interrupt);
         end else begin
            e = q.pop_front();
            if (interrupt !== e.exp[0]) begin
               n_miss++;
               $display("FAIL %s: interrupt got %b expected %b", e.name, interrupt, e.exp[0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
      exp_t e;
      e.name = name; e.exp = exp; e.is_irq = 1'b0;
      q.push_back(e);
      port_id = addr;
      ren = 1'b1;
      tick();
      ren = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id = addr;
      port_in = data;
      wen = 1'b1;
      tick();
      wen = 1'b0;
      port_in = 8'h00;
   endtask

   task automatic chk_int(input logic exp, input string name);
      exp_t e;
      e.name = name; e.exp = {7'b0, exp}; e.is_irq = 1'b1;
      q.push_back(e);
      chk_irq = 1'b1;
      tick();
      chk_irq = 1'b0;
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
   endtask

   initial begin
      // Reset held low while registers and IRQ line are probed.
      tick(); tick();
      rd(8'h20, 8'h00, "rst_mask");
      rd(8'h21, 8'h00, "rst_pend");
      rd(8'h22, 8'h00, "rst_vec");
      chk_int(1'b0, "rst_irq");
      rst = 1'b1;
      tick();

      // Single source: latency, ack, EOI.
      wr(8'h20, 8'h01);
      src_irq = 4'b0001; tick(); src_irq = 4'b0000;
      chk_int(1'b0, "t2_irq_after_1clk");
      rd(8'h21, 8'h01, "t2_pend");
      chk_int(1'b1, "t2_irq_after_2clk");
      ack();
      chk_int(1'b0, "t2_irq_after_ack");
      rd(8'h22, 8'h80, "t2_vec_service");
      rd(8'h21, 8'h00, "t2_pend_cleared");
      wr(8'h22, 8'h00);
      rd(8'h22, 8'h00, "t2_vec_eoi");
      chk_int(1'b0, "t2_irq_idle");

      // Two simultaneous sources: priority and re-assert after EOI.
      wr(8'h20, 8'h0F);
      src_irq = 4'b0110; tick(); src_irq = 4'b0000;
      tick();
      chk_int(1'b1, "t3_irq");
      ack();
      rd(8'h22, 8'h81, "t3_vec1");
      rd(8'h21, 8'h04, "t3_pend_left");
      chk_int(1'b0, "t3_irq_service");
      wr(8'h22, 8'h00);
      chk_int(1'b0, "t3_irq_eoi_1clk");
      chk_int(1'b1, "t3_irq_eoi_2clk");
      ack();
      rd(8'h22, 8'h82, "t3_vec2");
      wr(8'h22, 8'h00);
      rd(8'h22, 8'h02, "t3_vec2_eoi");
      chk_int(1'b0, "t3_irq_idle");

      // Masked source, W1C, set-beats-clear, unused bits, unaddressed read.
      wr(8'h20, 8'h00);
      src_irq = 4'b1000; tick(); src_irq = 4'b0000;
      rd(8'h21, 8'h08, "t4_pend_masked");
      chk_int(1'b0, "t4_irq_masked_a");
      chk_int(1'b0, "t4_irq_masked_b");
      wr(8'h21, 8'h08);
      rd(8'h21, 8'h00, "t4_pend_w1c");
      src_irq = 4'b1000; wr(8'h21, 8'h08); src_irq = 4'b0000;
      rd(8'h21, 8'h08, "t4_set_wins");
      wr(8'h21, 8'h08);
      rd(8'h21, 8'h00, "t4_pend_cleared");
      wr(8'h20, 8'hFF);
      rd(8'h20, 8'h0F, "t4_mask_upper0");
      rd(8'h23, 8'h00, "t4_unaddressed");
      wr(8'h20, 8'h00);

      // Held source sets pending once; reset in SERVICE clears everything.
      wr(8'h20, 8'h01);
      src_irq = 4'b0001;
      tick(); tick();
      chk_int(1'b1, "t5_irq_held");
      ack();
      repeat (44) tick();
      rd(8'h21, 8'h00, "t5_held_once");
      rd(8'h22, 8'h80, "t5_vec_service");
      src_irq = 4'b0000;
      wr(8'h20, 8'h0F);
      src_irq = 4'b0100; tick(); src_irq = 4'b0000;
      rd(8'h21, 8'h04, "t5_pend_in_service");
      chk_int(1'b0, "t5_irq_service");
      rst = 1'b0; tick(); rst = 1'b1;
      rd(8'h20, 8'h00, "t5_rst_mask");
      rd(8'h21, 8'h00, "t5_rst_pend");
      rd(8'h22, 8'h00, "t5_rst_vec");
      chk_int(1'b0, "t5_rst_irq");

`ifdef IRQ_TIMEOUT_EN
      // Unacknowledged request times out after 16 cycles and re-arbitrates.
      wr(8'h20, 8'h01);
      src_irq = 4'b0001; tick(); src_irq = 4'b0000;
      chk_int(1'b0, "t6_irq_pre");
      for (int i = 0; i < 16; i++) chk_int(1'b1, "t6_irq_asserted");
      chk_int(1'b0, "t6_irq_timeout_drop");
      chk_int(1'b1, "t6_irq_reassert");
      rd(8'h22, 8'h40, "t6_vec_tmo_flag");
      ack();
      rd(8'h22, 8'hC0, "t6_vec_service_flag");
      wr(8'h22, 8'h00);
      rd(8'h22, 8'h00, "t6_vec_eoi_clears");
`endif

      tick();
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
